// File: rtl/gat_aggregator_v2_pkg.sv
// Shared types and width helpers for the GAT aggregation stage.
// The accumulator width is sized so that a full neighbour list of extreme values cannot overflow.
package gat_aggregator_v2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    ROUND,
    OUTPUT
  } aggr_state_t;

  function automatic int gat_aggr_acc_w(input int data_w, input int alpha_w, input int max_nbr);
    return data_w + alpha_w + $clog2(max_nbr) + 1;
  endfunction

  localparam int GAT_AGGR_ACC_W = gat_aggr_acc_w(8, 8, 32);

endpackage

// File: rtl/gat_aggregator_v2_lane.sv
// One feature lane: weighted accumulate, fixed-point rescale, optional ReLU and saturation.
// The result is registered and held until the next round_en.
module gat_aggr_lane
  import gat_aggregator_v2_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ALPHA_WIDTH = 8,
  parameter int FRAC_BITS   = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int ACC_W       = GAT_AGGR_ACC_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          mac_en,
  input  logic signed [DATA_WIDTH-1:0]  din,
  input  logic        [ALPHA_WIDTH-1:0] alpha,
  input  logic                          relu_en,
  input  logic                          round_en,
  output logic signed [OUT_WIDTH-1:0]   dout
);

  localparam int PROD_W = DATA_WIDTH + ALPHA_WIDTH + 1;

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0]     r_acc;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_shift;
  logic signed [ACC_W-1:0]     w_relu;
  logic signed [OUT_WIDTH-1:0] w_sat;

  // Alpha is unsigned, so it gets a zero sign bit before the signed multiply.
  assign w_prod     = din * $signed({1'b0, alpha});
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_shift    = r_acc >>> FRAC_BITS;

  always_comb begin
    w_relu = w_shift;
    if (relu_en && (w_shift < 0)) begin
      w_relu = '0;
    end
    w_sat = w_relu[OUT_WIDTH-1:0];
    if (w_relu > OUT_MAX) begin
      w_sat = OUT_MAX[OUT_WIDTH-1:0];
    end else if (w_relu < OUT_MIN) begin
      w_sat = OUT_MIN[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      dout  <= '0;
    end else begin
      if (clr) begin
        r_acc <= '0;
      end else if (mac_en) begin
        r_acc <= r_acc + w_prod_ext;
      end
      if (round_en) begin
        dout <= w_sat;
      end
    end
  end

endmodule

// File: rtl/gat_aggregator_v2.sv
// GAT aggregation for one target node: streams neighbour WH rows from BRAM, alpha-weights and
// sums them across all feature lanes, then rescales and hands the row off on a valid/ready port.
module gat_aggregator_v2
  import gat_aggregator_v2_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ALPHA_WIDTH   = 8,
  parameter int FRAC_BITS     = 8,
  parameter int NUM_FEATURES  = 16,
  parameter int MAX_NEIGHBORS = 32,
  parameter int ADDR_W        = 10,
  parameter int BRAM_LAT      = 1,
  parameter int OUT_WIDTH     = 8,
  parameter int CNT_W         = $clog2(MAX_NEIGHBORS) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 aggr_valid_i,
  output logic                                 aggr_ready_o,
  output logic                                 aggr_pre_ready_o,
  input  logic [ADDR_W-1:0]                    base_addr_i,
  input  logic [CNT_W-1:0]                     num_nbr_i,
  input  logic [MAX_NEIGHBORS*ALPHA_WIDTH-1:0] alpha_i,
  input  logic                                 relu_en_i,
  output logic [ADDR_W-1:0]                    WH_BRAM_addrb,
  output logic                                 WH_BRAM_enb,
  input  logic [NUM_FEATURES*DATA_WIDTH-1:0]   WH_BRAM_doutb,
  output logic [NUM_FEATURES*OUT_WIDTH-1:0]    h_next_o,
  output logic                                 h_next_valid_o,
  input  logic                                 h_next_ready_i
);

  localparam int ACC_W = gat_aggr_acc_w(DATA_WIDTH, ALPHA_WIDTH, MAX_NEIGHBORS);
  localparam int KW    = (MAX_NEIGHBORS > 1) ? $clog2(MAX_NEIGHBORS) : 1;

  aggr_state_t r_state;
  logic                                 r_ready;
  logic                                 r_valid;
  logic                                 r_enb;
  logic [ADDR_W-1:0]                    r_addr;
  logic [CNT_W-1:0]                     r_k;
  logic [CNT_W-1:0]                     r_n;
  logic [MAX_NEIGHBORS*ALPHA_WIDTH-1:0] r_alpha;
  logic                                 r_relu;
  logic                                 r_dl_valid [BRAM_LAT];
  logic [KW-1:0]                        r_dl_k     [BRAM_LAT];

  logic [CNT_W-1:0]       w_n_clamp;
  logic                   w_accept;
  logic                   w_dl_pending;
  logic                   w_mac_en;
  logic                   w_round_en;
  logic [ALPHA_WIDTH-1:0] w_alpha_sel;

  assign w_n_clamp  = (num_nbr_i > CNT_W'(MAX_NEIGHBORS)) ? CNT_W'(MAX_NEIGHBORS) : num_nbr_i;
  assign w_accept   = (r_state == IDLE) && aggr_valid_i;
  assign w_mac_en   = r_dl_valid[BRAM_LAT-1];
  assign w_round_en = (r_state == ROUND);
  assign w_alpha_sel = r_alpha[int'(r_dl_k[BRAM_LAT-1])*ALPHA_WIDTH +: ALPHA_WIDTH];

  // The last stage MACs this cycle, so only earlier stages keep DRAIN waiting.
  always_comb begin
    w_dl_pending = 1'b0;
    for (int i = 0; i < BRAM_LAT - 1; i++) begin
      w_dl_pending = w_dl_pending | r_dl_valid[i];
    end
  end

  assign aggr_ready_o     = r_ready;
  assign aggr_pre_ready_o = (r_state == OUTPUT) && h_next_ready_i;
  assign h_next_valid_o   = r_valid;
  assign WH_BRAM_enb      = r_enb;
  assign WH_BRAM_addrb    = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BRAM_LAT; i++) begin
        r_dl_valid[i] <= 1'b0;
        r_dl_k[i]     <= '0;
      end
    end else begin
      r_dl_valid[0] <= r_enb;
      r_dl_k[0]     <= r_k[KW-1:0];
      for (int i = 1; i < BRAM_LAT; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_k[i]     <= r_dl_k[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_enb   <= 1'b0;
      r_addr  <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_alpha <= '0;
      r_relu  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (aggr_valid_i) begin
            r_ready <= 1'b0;
            r_n     <= w_n_clamp;
            r_alpha <= alpha_i;
            r_relu  <= relu_en_i;
            r_addr  <= base_addr_i;
            r_k     <= '0;
            if (w_n_clamp != '0) begin
              r_enb   <= 1'b1;
              r_state <= FETCH;
            end else begin
              r_state <= ROUND;
            end
          end
        end
        FETCH: begin
          if (r_k == r_n - CNT_W'(1)) begin
            r_enb   <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_k    <= r_k + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (!w_dl_pending) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_valid <= 1'b1;
          r_state <= OUTPUT;
        end
        OUTPUT: begin
          if (h_next_ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_lane
    gat_aggr_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ALPHA_WIDTH(ALPHA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .OUT_WIDTH  (OUT_WIDTH),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_accept),
      .mac_en  (w_mac_en),
      .din     ($signed(WH_BRAM_doutb[f*DATA_WIDTH +: DATA_WIDTH])),
      .alpha   (w_alpha_sel),
      .relu_en (r_relu),
      .round_en(w_round_en),
      .dout    (h_next_o[f*OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule
